// File: rtl/matmul_sequencer.sv
// Matrix-multiply sequencer: one LOAD/FEED/DRAIN/WRITE/DONE pass per start request.
// Optional busy-cycle performance counter enabled by defining MATMUL_PERF_CNT_EN.
//
// state | meaning
// IDLE  | waiting for the control start bit
// LOAD  | fields latched, PE accumulators cleared
// FEED  | one A column / B row fetched per cycle, K cycles
// DRAIN | PE pipeline drain, DRAIN_CYCLES cycles
// WRITE | result rows written back (bias read first when mode = 1)
// DONE  | completion pulse to the control register
module matmul_sequencer #(
  parameter int DIM_W        = 2,
  parameter int MAX_DIM      = 4,
  parameter int DRAIN_CYCLES = 6,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_bit_i,
  input  logic             mode_bit_i,
  input  logic [1:0]       write_target_i,
  input  logic [1:0]       read_target_i,
  input  logic [DIM_W-1:0] n_dim_i,
  input  logic [DIM_W-1:0] k_dim_i,
  input  logic [DIM_W-1:0] m_dim_i,
  output logic             clear_start_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pe_clear_o,
  output logic             op_rd_en_o,
  output logic [DIM_W-1:0] op_k_o,
  output logic             sp_rd_en_o,
  output logic [1:0]       sp_rd_target_o,
  output logic             sp_wr_en_o,
  output logic [1:0]       sp_wr_target_o,
  output logic [DIM_W-1:0] row_o,
  output logic             bias_en_o,
  output logic [CNT_W-1:0] cycle_count_o
);

  localparam int IDX_W = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FEED, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t           state;
  logic             mode_q;
  logic             phase_q;
  logic [IDX_W-1:0] n_last_q;
  logic [IDX_W-1:0] k_last_q;
  logic [IDX_W-1:0] m_last_q;
  logic [DRN_W-1:0] drain_cnt;

  // M only masks PE columns downstream; it is held but drives no count here.
  logic unused_m_last;
  assign unused_m_last = ^m_last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= S_IDLE;
      mode_q         <= 1'b0;
      phase_q        <= 1'b0;
      n_last_q       <= '0;
      k_last_q       <= '0;
      m_last_q       <= '0;
      drain_cnt      <= '0;
      clear_start_o  <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      pe_clear_o     <= 1'b0;
      op_rd_en_o     <= 1'b0;
      op_k_o         <= '0;
      sp_rd_en_o     <= 1'b0;
      sp_rd_target_o <= '0;
      sp_wr_en_o     <= 1'b0;
      sp_wr_target_o <= '0;
      row_o          <= '0;
      bias_en_o      <= 1'b0;
    end else begin
      clear_start_o <= 1'b0;
      done_o        <= 1'b0;
      pe_clear_o    <= 1'b0;
      op_rd_en_o    <= 1'b0;
      sp_rd_en_o    <= 1'b0;
      sp_wr_en_o    <= 1'b0;
      bias_en_o     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_bit_i) begin
            state          <= S_LOAD;
            busy_o         <= 1'b1;
            pe_clear_o     <= 1'b1;
            mode_q         <= mode_bit_i;
            sp_rd_target_o <= read_target_i;
            sp_wr_target_o <= write_target_i;
            n_last_q       <= IDX_W'(n_dim_i);
            k_last_q       <= IDX_W'(k_dim_i);
            m_last_q       <= IDX_W'(m_dim_i);
          end
        end
        S_LOAD: begin
          state      <= S_FEED;
          op_rd_en_o <= 1'b1;
          op_k_o     <= '0;
        end
        S_FEED: begin
          if (op_k_o == DIM_W'(k_last_q)) begin
            state     <= S_DRAIN;
            op_k_o    <= '0;
            drain_cnt <= DRN_W'(DRAIN_CYCLES - 1);
          end else begin
            op_rd_en_o <= 1'b1;
            op_k_o     <= op_k_o + DIM_W'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state   <= S_WRITE;
            row_o   <= '0;
            phase_q <= 1'b0;
            if (mode_q) sp_rd_en_o <= 1'b1;
            else        sp_wr_en_o <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DRN_W'(1);
          end
        end
        S_WRITE: begin
          // Bias mode: read row r one cycle, write it (with bias) the next.
          if (mode_q && !phase_q) begin
            phase_q    <= 1'b1;
            sp_wr_en_o <= 1'b1;
            bias_en_o  <= 1'b1;
          end else if (row_o == DIM_W'(n_last_q)) begin
            state         <= S_DONE;
            phase_q       <= 1'b0;
            row_o         <= '0;
            clear_start_o <= 1'b1;
            done_o        <= 1'b1;
          end else begin
            phase_q <= 1'b0;
            row_o   <= row_o + DIM_W'(1);
            if (mode_q) sp_rd_en_o <= 1'b1;
            else        sp_wr_en_o <= 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef MATMUL_PERF_CNT_EN
  logic [CNT_W-1:0] perf_cnt;

  // Restarting at 1 on the start edge counts the LOAD cycle itself.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cnt      <= '0;
      cycle_count_o <= '0;
    end else begin
      if (state == S_IDLE && start_bit_i) perf_cnt <= CNT_W'(1);
      else if (busy_o)                    perf_cnt <= perf_cnt + CNT_W'(1);
      if (state == S_DONE) cycle_count_o <= perf_cnt;
    end
  end
`else
  assign cycle_count_o = '0;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: a per-run expected cycle trace is queued
// at start and a negedge monitor pops and compares it on every busy cycle.
module tb_matmul_sequencer;

  logic        clk_i;
  logic        rst_ni;
  logic        start_bit_i;
  logic        mode_bit_i;
  logic [1:0]  write_target_i;
  logic [1:0]  read_target_i;
  logic [1:0]  n_dim_i;
  logic [1:0]  k_dim_i;
  logic [1:0]  m_dim_i;
  logic        clear_start_o;
  logic        busy_o;
  logic        done_o;
  logic        pe_clear_o;
  logic        op_rd_en_o;
  logic [1:0]  op_k_o;
  logic        sp_rd_en_o;
  logic [1:0]  sp_rd_target_o;
  logic        sp_wr_en_o;
  logic [1:0]  sp_wr_target_o;
  logic [1:0]  row_o;
  logic        bias_en_o;
  logic [15:0] cycle_count_o;

  typedef struct packed {
    logic       pe_clear;
    logic       op_rd_en;
    logic [1:0] op_k;
    logic       sp_rd_en;
    logic       sp_wr_en;
    logic [1:0] row;
    logic       bias_en;
    logic       done;
    logic       clear_start;
    logic [1:0] rd_tgt;
    logic [1:0] wr_tgt;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_act;
  ev_t mon_exp;
  int  checks = 0;
  int  errors = 0;

  matmul_sequencer dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_bit_i    (start_bit_i),
    .mode_bit_i     (mode_bit_i),
    .write_target_i (write_target_i),
    .read_target_i  (read_target_i),
    .n_dim_i        (n_dim_i),
    .k_dim_i        (k_dim_i),
    .m_dim_i        (m_dim_i),
    .clear_start_o  (clear_start_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .pe_clear_o     (pe_clear_o),
    .op_rd_en_o     (op_rd_en_o),
    .op_k_o         (op_k_o),
    .sp_rd_en_o     (sp_rd_en_o),
    .sp_rd_target_o (sp_rd_target_o),
    .sp_wr_en_o     (sp_wr_en_o),
    .sp_wr_target_o (sp_wr_target_o),
    .row_o          (row_o),
    .bias_en_o      (bias_en_o),
    .cycle_count_o  (cycle_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference trace of one operation, built from the phase lengths alone.
  task automatic push_run(input logic mode, input logic [1:0] n, input logic [1:0] k,
                          input logic [1:0] rd, input logic [1:0] wr);
    ev_t e;
    e = '0;
    e.rd_tgt = rd;
    e.wr_tgt = wr;
    e.pe_clear = 1'b1;
    exp_q.push_back(e);
    e.pe_clear = 1'b0;
    for (int i = 0; i <= int'(k); i++) begin
      e.op_rd_en = 1'b1;
      e.op_k     = 2'(i);
      exp_q.push_back(e);
    end
    e.op_rd_en = 1'b0;
    e.op_k     = '0;
    repeat (6) exp_q.push_back(e);
    for (int r = 0; r <= int'(n); r++) begin
      e.row = 2'(r);
      if (mode) begin
        e.sp_rd_en = 1'b1;
        exp_q.push_back(e);
        e.sp_rd_en = 1'b0;
      end
      e.sp_wr_en = 1'b1;
      e.bias_en  = mode;
      exp_q.push_back(e);
      e.sp_wr_en = 1'b0;
      e.bias_en  = 1'b0;
    end
    e.row         = '0;
    e.done        = 1'b1;
    e.clear_start = 1'b1;
    exp_q.push_back(e);
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      checks++;
      if (busy_o) begin
        mon_act = {pe_clear_o, op_rd_en_o, op_k_o, sp_rd_en_o, sp_wr_en_o, row_o,
                   bias_en_o, done_o, clear_start_o, sp_rd_target_o, sp_wr_target_o};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL busy_extra: busy with no expected cycle, outputs=%h", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            errors++;
            $display("FAIL cycle_trace at %0t: actual=%h expected=%h", $time, mon_act, mon_exp);
          end
        end
      end else if ({clear_start_o, done_o, pe_clear_o, op_rd_en_o, sp_rd_en_o,
                    sp_wr_en_o, bias_en_o} !== 7'b0) begin
        errors++;
        $display("FAIL idle_strobes at %0t: actual=%b expected=0000000", $time,
                 {clear_start_o, done_o, pe_clear_o, op_rd_en_o, sp_rd_en_o, sp_wr_en_o, bias_en_o});
      end
    end
  end

  task automatic run(input logic mode, input logic [1:0] n, input logic [1:0] k,
                     input logic [1:0] m, input logic [1:0] rd, input logic [1:0] wr,
                     input bit scramble);
    int lat;
    int exp_cc;
    bit seen;
    lat = 2 + (int'(k) + 1) + 6 + (int'(n) + 1) * (mode ? 2 : 1);
`ifdef MATMUL_PERF_CNT_EN
    exp_cc = lat;
`else
    exp_cc = 0;
`endif
    @(negedge clk_i);
    mode_bit_i     = mode;
    n_dim_i        = n;
    k_dim_i        = k;
    m_dim_i        = m;
    read_target_i  = rd;
    write_target_i = wr;
    push_run(mode, n, k, rd, wr);
    start_bit_i = 1'b1;
    if (scramble) begin
      repeat (2) @(negedge clk_i);
      mode_bit_i     = 1'($urandom_range(1));
      n_dim_i        = 2'($urandom_range(3));
      k_dim_i        = 2'($urandom_range(3));
      m_dim_i        = 2'($urandom_range(3));
      read_target_i  = 2'($urandom_range(3));
      write_target_i = 2'($urandom_range(3));
    end
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk_i);
      if (done_o) seen = 1'b1;
    end
    // the control register drops start on the DONE edge
    start_bit_i = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: no done_o within 200 cycles, expected after %0d", lat);
    end
    @(negedge clk_i);
    checks++;
    if (int'(cycle_count_o) != exp_cc) begin
      errors++;
      $display("FAIL cycle_count: actual=%0d expected=%0d", cycle_count_o, exp_cc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL trace_short: %0d expected cycles left unconsumed, expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    rst_ni         = 1'b0;
    start_bit_i    = 1'b0;
    mode_bit_i     = 1'b0;
    write_target_i = '0;
    read_target_i  = '0;
    n_dim_i        = '0;
    k_dim_i        = '0;
    m_dim_i        = '0;
    #1;
    checks++;
    if ({clear_start_o, busy_o, done_o, pe_clear_o, op_rd_en_o, op_k_o, sp_rd_en_o,
         sp_rd_target_o, sp_wr_en_o, sp_wr_target_o, row_o, bias_en_o, cycle_count_o} !== '0) begin
      errors++;
      $display("FAIL reset_state: actual busy=%b row=%h cc=%0d expected all zero", busy_o, row_o, cycle_count_o);
    end
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    run(1'b0, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 1'b0);
    run(1'b1, 2'd3, 2'd3, 2'd3, 2'd1, 2'd2, 1'b0);
    run(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    run(1'b1, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 1'b1);

    // reset in the middle of DRAIN
    @(negedge clk_i);
    mode_bit_i     = 1'b1;
    n_dim_i        = 2'd3;
    k_dim_i        = 2'd3;
    read_target_i  = 2'd2;
    write_target_i = 2'd3;
    push_run(1'b1, 2'd3, 2'd3, 2'd2, 2'd3);
    start_bit_i = 1'b1;
    repeat (7) @(negedge clk_i);
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({clear_start_o, busy_o, done_o, pe_clear_o, op_rd_en_o, op_k_o, sp_rd_en_o,
         sp_rd_target_o, sp_wr_en_o, sp_wr_target_o, row_o, bias_en_o, cycle_count_o} !== '0) begin
      errors++;
      $display("FAIL reset_abort: actual busy=%b clr=%b tgt=%h/%h cc=%0d expected all zero",
               busy_o, clear_start_o, sp_rd_target_o, sp_wr_target_o, cycle_count_o);
    end
    exp_q.delete();
    start_bit_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: actual busy=%b expected 0", busy_o);
    end

    for (int t = 0; t < 25; t++) begin
      run(1'($urandom_range(1)), 2'($urandom_range(3)), 2'($urandom_range(3)),
          2'($urandom_range(3)), 2'($urandom_range(3)), 2'($urandom_range(3)), 1'b1);
    end

    repeat (3) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
